// File: rtl/axi_wr_back_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the
// write-response arbiter.
package axi_wr_back_pkg;

  localparam int N_SRC       = 4;
  localparam int ID_WIDTH    = 8;
  localparam int SEQ_WIDTH   = 7;
  localparam int RESP_WIDTH  = 2;
  localparam int SRC_WIDTH   = 2;
  localparam int ERR_WIDTH   = 16;
  localparam int ENTRY_WIDTH = RESP_WIDTH + ID_WIDTH + SRC_WIDTH + SEQ_WIDTH;

  // Entry field offsets (LSB position of each field)
  localparam int RESP_LSB = 0;
  localparam int BID_LSB  = RESP_LSB + RESP_WIDTH;
  localparam int SRC_LSB  = BID_LSB + ID_WIDTH;
  localparam int SEQ_LSB  = SRC_LSB + SRC_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  // Build one FIFO entry from its fields.
  function automatic logic [ENTRY_WIDTH-1:0] pack_entry(
    input logic [SEQ_WIDTH-1:0]  seq,
    input logic [SRC_WIDTH-1:0]  src,
    input logic [ID_WIDTH-1:0]   bid,
    input logic [RESP_WIDTH-1:0] resp
  );
    logic [ENTRY_WIDTH-1:0] e;
    e = {ENTRY_WIDTH{1'b0}};
    e[RESP_LSB +: RESP_WIDTH] = resp;
    e[BID_LSB  +: ID_WIDTH]   = bid;
    e[SRC_LSB  +: SRC_WIDTH]  = src;
    e[SEQ_LSB  +: SEQ_WIDTH]  = seq;
    return e;
  endfunction

endpackage

// File: rtl/axi_wr_back_arbiter_rr_arb4.sv
// Four-way round-robin grant: first requester at or above ptr, wrapping.
module rr_arb4
  import axi_wr_back_pkg::*;
(
  input  logic [N_SRC-1:0]     req,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic [N_SRC-1:0]     grant
);

  logic [SRC_WIDTH-1:0] idx_s;

  // Walk the requesters from ptr upward and grant the first one found.
  always_comb begin
    grant = {N_SRC{1'b0}};
    idx_s = {SRC_WIDTH{1'b0}};
    for (int k = 0; k < N_SRC; k++) begin
      idx_s = ptr + SRC_WIDTH'(k);
      if (req[idx_s] && (grant == {N_SRC{1'b0}})) begin
        grant[idx_s] = 1'b1;
      end else begin
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/axi_wr_back_arbiter.sv
// Arbitrates N_SRC AXI write-response channels into one write-back FIFO,
// tagging each entry with source index and a wrapping sequence number.
module axi_wr_back_arbiter #(
  parameter int N_SRC     = axi_wr_back_pkg::N_SRC,
  parameter int ID_WIDTH  = axi_wr_back_pkg::ID_WIDTH,
  parameter int SEQ_WIDTH = axi_wr_back_pkg::SEQ_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_SRC-1:0]          s_bvalid,
  output logic [N_SRC-1:0]          s_bready,
  input  logic [N_SRC*ID_WIDTH-1:0] s_bid,
  input  logic [N_SRC*2-1:0]        s_bresp,
  output logic                      fifo_wr_en,
  output logic [18:0]               fifo_wr_data,
  input  logic                      fifo_wr_full,
  input  logic                      fifo_almost_full,
  input  logic                      err_clr,
  output logic [15:0]               err_cnt,
  output logic [1:0]                state
);

  import axi_wr_back_pkg::*;

  logic                   blocked_s;
  logic [N_SRC-1:0]       req_s;
  logic [N_SRC-1:0]       grant_s;
  logic                   hs_s;
  logic                   err_hit_s;
  logic [SRC_WIDTH-1:0]   win_s;
  logic [ID_WIDTH-1:0]    bid_s;
  logic [RESP_WIDTH-1:0]  resp_s;
  state_t                 next_state_s;

  logic [SRC_WIDTH-1:0]   rr_ptr_r;
  logic [SEQ_WIDTH-1:0]   seq_r;
  logic [ERR_WIDTH-1:0]   err_cnt_r;
  logic                   wr_en_r;
  logic [ENTRY_WIDTH-1:0] wr_data_r;
  state_t                 state_r;

  // Backpressure uses almost-full so the in-flight entry always has room;
  // readiness is also withheld while reset is asserted.
  assign blocked_s = fifo_almost_full | fifo_wr_full;
  assign req_s     = (rstn && !blocked_s) ? s_bvalid : {N_SRC{1'b0}};

  rr_arb4 u_rr_arb4 (
    .req   (req_s),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  assign s_bready  = grant_s;
  assign hs_s      = |grant_s;
  assign err_hit_s = hs_s && (resp_s != 2'b00);

  // Select the winning source's index, BID and BRESP.
  always_comb begin
    win_s  = {SRC_WIDTH{1'b0}};
    bid_s  = {ID_WIDTH{1'b0}};
    resp_s = 2'b00;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_s[i]) begin
        win_s  = SRC_WIDTH'(i);
        bid_s  = s_bid[i*ID_WIDTH +: ID_WIDTH];
        resp_s = s_bresp[i*2 +: 2];
      end else begin
        win_s  = win_s;
        bid_s  = bid_s;
        resp_s = resp_s;
      end
    end
  end

  // Next FSM state reflects this cycle's valid/backpressure situation.
  always_comb begin
    case ({|s_bvalid, blocked_s})
      2'b10:   next_state_s = ST_ACCEPT;
      2'b11:   next_state_s = ST_BLOCKED;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Registered write-back path, pointer, sequence tag, error count and state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r  <= {SRC_WIDTH{1'b0}};
      seq_r     <= {SEQ_WIDTH{1'b0}};
      err_cnt_r <= {ERR_WIDTH{1'b0}};
      wr_en_r   <= 1'b0;
      wr_data_r <= {ENTRY_WIDTH{1'b0}};
      state_r   <= ST_IDLE;
    end else begin
      wr_en_r <= hs_s;
      state_r <= next_state_s;
      if (hs_s) begin
        wr_data_r <= pack_entry(seq_r, win_s, bid_s, resp_s);
        rr_ptr_r  <= win_s + 2'd1;
        seq_r     <= seq_r + 7'd1;
      end
      if (err_clr) begin
        err_cnt_r <= err_hit_s ? 16'd1 : 16'd0;
      end else if (err_hit_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign fifo_wr_en   = wr_en_r;
  assign fifo_wr_data = wr_data_r;
  assign err_cnt      = err_cnt_r;
  assign state        = state_r;

endmodule

// File: tb/tb_axi_wr_back_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// every cycle against a behavioural model of the arbiter.
module tb_axi_wr_back_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  s_bvalid;
  logic [3:0]  s_bready;
  logic [31:0] s_bid;
  logic [7:0]  s_bresp;
  logic        fifo_wr_en;
  logic [18:0] fifo_wr_data;
  logic        fifo_wr_full;
  logic        fifo_almost_full;
  logic        err_clr;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] dut_log[$];

  // behavioural model state (what the registered outputs must be now)
  int          m_ptr = 0;
  int          m_seq = 0;
  int          m_err = 0;
  int          m_state = 0;
  logic        m_en = 1'b0;
  logic [18:0] m_data = 19'd0;

  int          c_src;
  int          c_j;
  logic        c_blk;
  logic [3:0]  c_rdy;
  logic [1:0]  c_resp;
  logic [7:0]  c_bid;
  logic [1:0]  c_src2;
  logic [6:0]  c_seq7;
  logic [18:0] e;

  always #5 clk = ~clk;

  axi_wr_back_arbiter dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_bvalid         (s_bvalid),
    .s_bready         (s_bready),
    .s_bid            (s_bid),
    .s_bresp          (s_bresp),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_full     (fifo_wr_full),
    .fifo_almost_full (fifo_almost_full),
    .err_clr          (err_clr),
    .err_cnt          (err_cnt),
    .state            (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Compare process: check DUT against model, then advance the model.
  always @(negedge clk) begin
    c_blk = fifo_almost_full | fifo_wr_full;
    c_src = -1;
    if (rstn === 1'b1 && !c_blk) begin
      for (int k = 0; k < 4; k++) begin
        c_j = (m_ptr + k) % 4;
        if (s_bvalid[c_j] && c_src < 0) c_src = c_j;
      end
    end
    c_rdy = (c_src >= 0) ? (4'b0001 << c_src) : 4'b0000;
    if (rstn !== 1'b1) begin
      m_en = 1'b0; m_data = 19'd0; m_err = 0; m_state = 0; m_ptr = 0; m_seq = 0;
    end
    check("s_bready", {28'd0, s_bready}, {28'd0, c_rdy});
    check("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, m_en});
    check("fifo_wr_data", {13'd0, fifo_wr_data}, {13'd0, m_data});
    check("err_cnt", {16'd0, err_cnt}, m_err);
    check("state", {30'd0, state}, m_state);
    if (fifo_wr_en === 1'b1) dut_log.push_back(fifo_wr_data);
    if (rstn === 1'b1) begin
      c_resp = 2'b00;
      m_en = (c_src >= 0);
      if (c_src >= 0) begin
        c_resp = s_bresp[c_src*2 +: 2];
        c_bid  = s_bid[c_src*8 +: 8];
        c_src2 = c_src[1:0];
        c_seq7 = m_seq[6:0];
        m_data = {c_seq7, c_src2, c_bid, c_resp};
        m_ptr  = (c_src + 1) % 4;
        m_seq  = (m_seq + 1) % 128;
      end
      if (err_clr) m_err = (c_src >= 0 && c_resp != 2'b00) ? 1 : 0;
      else if (c_src >= 0 && c_resp != 2'b00 && m_err < 65535) m_err = m_err + 1;
      m_state = (s_bvalid == 4'b0000) ? 0 : (c_blk ? 2 : 1);
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  logic [18:0] exp032 [5] = '{19'h00040, 19'h01444, 19'h02848, 19'h03C4C, 19'h04040};

  initial begin
    rstn = 1'b0; s_bvalid = 4'd0; s_bid = 32'd0; s_bresp = 8'd0;
    fifo_wr_full = 1'b0; fifo_almost_full = 1'b0; err_clr = 1'b0;
    tick();
    #1;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_wr_data", {13'd0, fifo_wr_data}, 32'd0);
    do_reset();

    // all four sources valid continuously
    dut_log.delete();
    s_bid = {8'h13, 8'h12, 8'h11, 8'h10};
    s_bvalid = 4'hF;
    repeat (6) tick();
    s_bvalid = 4'h0;
    repeat (2) tick();
    check("rr_log_size", dut_log.size(), 32'd6);
    for (int k = 0; k < 5; k++)
      if (k < dut_log.size()) check("rr_entry", {13'd0, dut_log[k]}, {13'd0, exp032[k]});

    // almost-full blocks source 2, then release
    dut_log.delete();
    fifo_almost_full = 1'b1;
    s_bvalid = 4'b0100;
    repeat (5) begin
      #1 check("blocked_ready", {28'd0, s_bready}, 32'd0);
      tick();
    end
    check("blocked_state", {30'd0, state}, 32'd2);
    fifo_almost_full = 1'b0;
    #1 check("release_ready", {28'd0, s_bready}, 32'd4);
    tick();
    s_bvalid = 4'b0000;
    repeat (2) tick();
    check("release_log_size", dut_log.size(), 32'd1);
    if (dut_log.size() > 0) begin
      e = dut_log[0];
      check("release_src", {30'd0, e[11:10]}, 32'd2);
    end

    // 130 handshakes from source 1, sequence wrap
    do_reset();
    dut_log.delete();
    s_bid = {8'h00, 8'h00, 8'hA5, 8'h00};
    s_bvalid = 4'b0010;
    repeat (130) tick();
    s_bvalid = 4'b0000;
    repeat (2) tick();
    check("wrap_log_size", dut_log.size(), 32'd130);
    if (dut_log.size() == 130) begin
      check("wrap_first", {13'd0, dut_log[0]}, 32'h00694);
      check("wrap_127", {13'd0, dut_log[127]}, 32'h7F694);
      check("wrap_128", {13'd0, dut_log[128]}, 32'h00694);
      check("wrap_129", {13'd0, dut_log[129]}, 32'h01694);
    end

    // three SLVERR then err_clr with DECERR
    do_reset();
    s_bvalid = 4'b0001;
    s_bresp = 8'b0000_0010;
    repeat (3) tick();
    s_bvalid = 4'b0000;
    tick();
    check("err_three", {16'd0, err_cnt}, 32'd3);
    s_bvalid = 4'b0001;
    s_bresp = 8'b0000_0011;
    err_clr = 1'b1;
    tick();
    s_bvalid = 4'b0000;
    err_clr = 1'b0;
    s_bresp = 8'd0;
    tick();
    check("err_clr_hit", {16'd0, err_cnt}, 32'd1);

    // reset right after a handshake
    s_bvalid = 4'b0001;
    tick();
    rstn = 1'b0;
    #1;
    check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_wr_data", {13'd0, fifo_wr_data}, 32'd0);
    check("rst_err", {16'd0, err_cnt}, 32'd0);
    check("rst_ready", {28'd0, s_bready}, 32'd0);
    dut_log.delete();
    tick();
    rstn = 1'b1;
    s_bvalid = 4'b0000;
    repeat (3) tick();
    check("rst_no_write", dut_log.size(), 32'd0);

    // source 3 drops valid while blocked
    dut_log.delete();
    fifo_almost_full = 1'b1;
    s_bvalid = 4'b1000;
    repeat (2) begin
      #1 check("drop_ready", {28'd0, s_bready}, 32'd0);
      tick();
    end
    s_bvalid = 4'b0000;
    tick();
    fifo_almost_full = 1'b0;
    repeat (2) tick();
    check("drop_no_write", dut_log.size(), 32'd0);

    // random traffic
    repeat (3000) begin
      s_bvalid = 4'($urandom_range(0, 15));
      s_bid = $urandom;
      s_bresp = 8'($urandom);
      fifo_almost_full = ($urandom_range(0, 9) < 2);
      fifo_wr_full = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 19) == 0);
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1'b1;
    s_bvalid = 4'd0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
